// File: rtl/history_checkpoint_recovery.sv
// Speculative/committed path-history tracker with per-branch checkpoints and mispredict recovery.
// Latency: one cycle to outputs. predict_ready drops when the checkpoint FIFO is full or during RECOVER.
module history_checkpoint_recovery #(
  parameter int HIST_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     predict_valid,
  input  logic                     predict_taken,
  output logic                     predict_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic [HIST_W-1:0]        spec_history,
  output logic [HIST_W-1:0]        commit_history,
  output logic                     mispredict,
  output logic                     resolve_error,
  output logic [$clog2(DEPTH):0]   inflight_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {TRACK, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [DEPTH-1:0] ckpt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            accept, res_hit, res_miss, res_empty, popped;

  assign predict_ready = (state == TRACK) && (inflight_count != FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= TRACK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    res_hit   = 1'b0;
    res_miss  = 1'b0;
    res_empty = 1'b0;
    popped    = ckpt[rd_ptr];
    case (state)
      TRACK: begin
        accept = predict_valid && predict_ready;
        if (resolve_valid) begin
          if (inflight_count == '0)       res_empty = 1'b1;
          else if (resolve_taken == popped) res_hit = 1'b1;
          else begin
            res_miss  = 1'b1;
            state_nxt = RECOVER;
          end
        end
      end
      RECOVER: begin
        // The FIFO was just flushed, so any resolve here has nothing to pop.
        res_empty = resolve_valid;
        state_nxt = TRACK;
      end
      default: state_nxt = TRACK;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      spec_history   <= '0;
      commit_history <= '0;
      mispredict     <= 1'b0;
      resolve_error  <= 1'b0;
      inflight_count <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      ckpt           <= '0;
    end else begin
      mispredict    <= res_miss;
      resolve_error <= res_empty;
      if (res_hit || res_miss)
        commit_history <= {commit_history[HIST_W-2:0], resolve_taken};
      if (res_miss) begin
        // Rebuild speculation from the corrected architectural path; drop any same-cycle predict.
        spec_history   <= {commit_history[HIST_W-2:0], resolve_taken};
        inflight_count <= '0;
        rd_ptr         <= wr_ptr;
      end else begin
        if (accept) begin
          ckpt[wr_ptr] <= predict_taken;
          wr_ptr       <= wr_ptr + 1'b1;
          spec_history <= {spec_history[HIST_W-2:0], predict_taken};
        end
        if (res_hit)
          rd_ptr <= rd_ptr + 1'b1;
        if (accept && !res_hit)
          inflight_count <= inflight_count + 1'b1;
        else if (!accept && res_hit)
          inflight_count <= inflight_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_history_checkpoint_recovery.sv
// Bench for history_checkpoint_recovery: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_history_checkpoint_recovery;

  localparam int HIST_W = 12;
  localparam int DEPTH  = 8;
  localparam int MASK   = (1 << HIST_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic predict_valid = 1'b0, predict_taken = 1'b0;
  logic resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic predict_ready, mispredict, resolve_error;
  logic [HIST_W-1:0] spec_history, commit_history;
  logic [$clog2(DEPTH):0] inflight_count;

  history_checkpoint_recovery #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .predict_valid(predict_valid), .predict_taken(predict_taken), .predict_ready(predict_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .spec_history(spec_history), .commit_history(commit_history),
    .mispredict(mispredict), .resolve_error(resolve_error), .inflight_count(inflight_count)
  );

  always #5 clock = ~clock;

  // Reference model: in-flight predictions as a queue, histories as integers.
  bit q[$];
  int m_spec, m_commit, m_mis, m_err, m_rec;
  int n_chk = 0, n_pass = 0;
  bit check_en = 1'b0;

  function automatic int m_ready();
    return (m_rec == 0 && q.size() < DEPTH) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_spec = 0; m_commit = 0; m_mis = 0; m_err = 0; m_rec = 0;
  endtask

  task automatic model_step(input bit pv, input bit pt, input bit rv, input bit rt);
    bit acc;
    bit pop;
    acc   = pv && (m_ready() != 0);
    m_mis = 0;
    m_err = 0;
    if (rv && m_rec == 0 && q.size() > 0) begin
      pop = q.pop_front();
      if (rt != pop) begin
        m_spec   = ((m_commit << 1) | int'(rt)) & MASK;
        m_commit = m_spec;
        q.delete();
        m_mis = 1;
        m_rec = 1;
        return;
      end
      m_commit = ((m_commit << 1) | int'(rt)) & MASK;
    end else if (rv) begin
      m_err = 1;
    end
    m_rec = 0;
    if (acc) begin
      q.push_back(pt);
      m_spec = ((m_spec << 1) | int'(pt)) & MASK;
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("predict_ready",  int'(predict_ready),  m_ready());
      chk("spec_history",   int'(spec_history),   m_spec);
      chk("commit_history", int'(commit_history), m_commit);
      chk("mispredict",     int'(mispredict),     m_mis);
      chk("resolve_error",  int'(resolve_error),  m_err);
      chk("inflight_count", int'(inflight_count), q.size());
    end
  end

  // Drive one cycle's inputs (called at posedge+1), then advance the model past the edge.
  task automatic cyc(input bit pv, input bit pt, input bit rv, input bit rt);
    predict_valid = pv; predict_taken = pt;
    resolve_valid = rv; resolve_taken = rt;
    @(posedge clock);
    #1;
    model_step(pv, pt, rv, rt);
    predict_valid = 1'b0; predict_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_en = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_spec",   int'(spec_history),   0);
    chk("rst_commit", int'(commit_history), 0);
    chk("rst_count",  int'(inflight_count), 0);
    chk("rst_mis",    int'(mispredict),     0);
    chk("rst_err",    int'(resolve_error),  0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_ready", int'(predict_ready), 1);
    check_en = 1'b1;

    // Push 1,0,1,1 without resolving.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("push4_spec",   int'(spec_history),   'h00B);
    chk("push4_commit", int'(commit_history), 0);
    chk("push4_count",  int'(inflight_count), 4);

    // Fill to DEPTH; a further predict (not-taken) must be dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0);
    chk("full_ready", int'(predict_ready), 0);
    cyc(1, 0, 0, 0);
    chk("full_spec",  int'(spec_history),   'h0FF);
    chk("full_count", int'(inflight_count), 8);

    // Mispredict on the oldest of 1,1,0.
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("mis_pulse",  int'(mispredict),     1);
    chk("mis_commit", int'(commit_history), 0);
    chk("mis_spec",   int'(spec_history),   0);
    chk("mis_count",  int'(inflight_count), 0);
    chk("mis_ready",  int'(predict_ready),  0);
    cyc(0, 0, 0, 0);
    chk("mis_clear",  int'(mispredict),     0);
    chk("rec_ready",  int'(predict_ready),  1);

    // Correct resolve alongside a predict at count 3.
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    chk("both_count",  int'(inflight_count), 3);
    chk("both_spec",   int'(spec_history),   'h00B);
    chk("both_commit", int'(commit_history), 'h001);

    // Resolve with nothing in flight.
    do_reset();
    cyc(1, 1, 0, 0); cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("err_pulse",  int'(resolve_error),  1);
    chk("err_spec",   int'(spec_history),   'h001);
    chk("err_commit", int'(commit_history), 'h001);
    cyc(0, 0, 0, 0);
    chk("err_clear",  int'(resolve_error),  0);

    // Async reset mid-stream with 5 in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    check_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_spec",   int'(spec_history),   0);
    chk("arst_commit", int'(commit_history), 0);
    chk("arst_count",  int'(inflight_count), 0);
    chk("arst_mis",    int'(mispredict),     0);
    chk("arst_err",    int'(resolve_error),  0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("arst_ready", int'(predict_ready), 1);
    check_en = 1'b1;

    // Random traffic; resolves mostly agree with the oldest prediction.
    for (int i = 0; i < 3000; i++) begin
      bit pv, pt, rv, rt;
      pv = ($urandom_range(0, 99) < 70);
      pt = $urandom_range(0, 1) != 0;
      rv = ($urandom_range(0, 99) < 40);
      if (q.size() > 0 && $urandom_range(0, 99) < 80) rt = q[0];
      else rt = $urandom_range(0, 1) != 0;
      cyc(pv, pt, rv, rt);
      if (i == 1500) do_reset();
    end

    // Reset taken while in RECOVER: no pulses afterwards.
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    do_reset();
    chk("rec_rst_mis",   int'(mispredict),    0);
    chk("rec_rst_ready", int'(predict_ready), 1);
    cyc(0, 0, 0, 0);

    check_en = 1'b0;
    @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
